// File: rtl/nand_gate_array_seq.sv
// nand_gate_array_seq
//   Registered, parametrised logic-gate array. An N_IN-bit operand and a gate
//   function (NAND/AND/NOR/OR) go through a two-stage pipeline. Stage 2 produces
//   a reduction gate over all operand bits and a gate over each adjacent bit pair.
//   Operands come from an external valid/ready port, or from a sweep generator
//   that walks every input combination.
//
// Parameters
//   N_IN      operand width (even, 2..16)
//   HOLD_CYC  cycles each sweep pattern stays in stage 1 (1..255)
//
// Ports
//   clk, rst_n            clock (rising edge) and synchronous active-low reset
//   mode[1:0]             00 NAND, 01 AND, 10 NOR, 11 OR; captured with each operand
//   ext_en                enables the external operand port while idle
//   ext_in, ext_valid     external operand and its valid strobe
//   ext_ready             external operand accepted on ext_valid & ext_ready
//   start, stop           begin a sweep (idle only) / end it after the current pattern
//   busy                  sweep or drain in progress, up to and including done
//   done                  one-cycle pulse after the last sweep result
//   out_valid             one-cycle pulse when out_* carry a new result
//   out_in, out_y         operand of this result and gate over all its bits
//   out_pair[N_IN/2]      out_pair[k] = gate over out_in[2k+1:2k]
//
// Build option
//   SWEEP_LOOP_EN  when defined, the sweep wraps from the last pattern back to 0
//                  and runs until stop. Otherwise a single pass is made.

module nand_gate_array_seq #(
    parameter int unsigned N_IN     = 4,
    parameter int unsigned HOLD_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              ext_en,
    input  logic [N_IN-1:0]   ext_in,
    input  logic              ext_valid,
    output logic              ext_ready,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    output logic [N_IN-1:0]   out_in,
    output logic              out_y,
    output logic [N_IN/2-1:0] out_pair
);

    localparam int unsigned NP = N_IN / 2;
    localparam int unsigned CW = N_IN + 1;
    localparam int unsigned HW = 8;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [N_IN-1:0] opnd;
        logic [1:0]      mode;
    } s1_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   pat_q, pat_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            stop_seen_q, stop_seen_d;
    s1_t             s1_q, s1_d;
    logic            s1_vld_q, s1_vld_d;
    logic            ext_ready_q, ext_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            out_valid_q, out_valid_d;
    logic [N_IN-1:0] out_in_q, out_in_d;
    logic            out_y_q, out_y_d;
    logic [NP-1:0]   out_pair_q, out_pair_d;

    logic [CW-1:0]   pat_inc;
    logic            wrap;
    logic            last_pat;
    logic            window_end;
    logic            stop_now;

    // Selected gate function from AND/OR of the inputs; mode[0]=0 inverts.
    function automatic logic gate_fn(input logic [1:0] m, input logic and_v, input logic or_v);
        logic base;
        base = m[1] ? or_v : and_v;
        return m[0] ? base : ~base;
    endfunction

    // Next-state, sweep issue and result computation.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        hold_d      = hold_q;
        stop_seen_d = stop_seen_q;
        s1_d        = s1_q;
        s1_vld_d    = 1'b0;
        done_d      = 1'b0;
        out_valid_d = 1'b0;
        out_in_d    = out_in_q;
        out_y_d     = out_y_q;
        out_pair_d  = out_pair_q;

        // The extra counter bit flags the step past the final pattern.
        pat_inc    = pat_q + CW'(1);
        wrap       = pat_inc[N_IN];
        window_end = (hold_q == HOLD_LAST);
        stop_now   = stop | stop_seen_q;
`ifdef SWEEP_LOOP_EN
        last_pat   = 1'b0;
`else
        last_pat   = wrap;
`endif

        unique case (state_q)
            ST_IDLE: begin
                // start outranks a simultaneous external operand.
                if (start && !busy_q) begin
                    state_d     = ST_SWEEP;
                    pat_d       = '0;
                    hold_d      = '0;
                    stop_seen_d = 1'b0;
                    s1_d.opnd   = '0;
                    s1_d.mode   = mode;
                    s1_vld_d    = 1'b1;
                end else if (ext_valid && ext_ready_q) begin
                    s1_d.opnd   = ext_in;
                    s1_d.mode   = mode;
                    s1_vld_d    = 1'b1;
                end
            end
            ST_SWEEP: begin
                if (stop) begin
                    stop_seen_d = 1'b1;
                end
                if (window_end) begin
                    if (stop_now || last_pat) begin
                        // Pattern still in stage 1 needs one more cycle to emerge.
                        if (s1_vld_q) begin
                            state_d = ST_DRAIN;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        pat_d     = wrap ? '0 : pat_inc;
                        hold_d    = '0;
                        s1_d.opnd = pat_inc[N_IN-1:0];
                        s1_d.mode = mode;
                        s1_vld_d  = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_DRAIN: begin
                if (!s1_vld_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stage 2: evaluate the gates on the captured operand.
        out_valid_d = s1_vld_q;
        if (s1_vld_q) begin
            out_in_d = s1_q.opnd;
            out_y_d  = gate_fn(s1_q.mode, &s1_q.opnd, |s1_q.opnd);
            for (int k = 0; k < int'(NP); k++) begin
                out_pair_d[k] = gate_fn(s1_q.mode,
                                        s1_q.opnd[2*k] & s1_q.opnd[2*k+1],
                                        s1_q.opnd[2*k] | s1_q.opnd[2*k+1]);
            end
        end

        busy_d      = (state_d != ST_IDLE) || done_d;
        ext_ready_d = ext_en && !busy_d;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            hold_q      <= '0;
            stop_seen_q <= 1'b0;
            s1_q        <= '0;
            s1_vld_q    <= 1'b0;
            ext_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_in_q    <= '0;
            out_y_q     <= 1'b0;
            out_pair_q  <= '0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            hold_q      <= hold_d;
            stop_seen_q <= stop_seen_d;
            s1_q        <= s1_d;
            s1_vld_q    <= s1_vld_d;
            ext_ready_q <= ext_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_in_q    <= out_in_d;
            out_y_q     <= out_y_d;
            out_pair_q  <= out_pair_d;
        end
    end

    assign ext_ready = ext_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_in    = out_in_q;
    assign out_y     = out_y_q;
    assign out_pair  = out_pair_q;

endmodule

// File: tb/tb_nand_gate_array_seq.sv
// Bench for nand_gate_array_seq: instance A (HOLD_CYC=1) and instance B (HOLD_CYC=3).
module tb_nand_gate_array_seq;

    localparam int unsigned N  = 4;
    localparam int unsigned NP = 2;
`ifdef SWEEP_LOOP_EN
    localparam int FULL_STOP_A = 16;
    localparam int FULL_STOP_B = 46;
`else
    localparam int FULL_STOP_A = -1;
    localparam int FULL_STOP_B = -1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [1:0]    mode_a, mode_b;
    logic          ext_en_a, ext_en_b, ext_valid_a, ext_valid_b;
    logic [N-1:0]  ext_in_a, ext_in_b;
    logic          start_a, start_b, stop_a, stop_b;
    logic          ext_ready_a, ext_ready_b, busy_a, busy_b, done_a, done_b;
    logic          out_valid_a, out_valid_b, out_y_a, out_y_b;
    logic [N-1:0]  out_in_a, out_in_b;
    logic [NP-1:0] out_pair_a, out_pair_b;

    nand_gate_array_seq #(.N_IN(N), .HOLD_CYC(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode_a), .ext_en(ext_en_a), .ext_in(ext_in_a),
        .ext_valid(ext_valid_a), .ext_ready(ext_ready_a), .start(start_a), .stop(stop_a),
        .busy(busy_a), .done(done_a), .out_valid(out_valid_a), .out_in(out_in_a),
        .out_y(out_y_a), .out_pair(out_pair_a));

    nand_gate_array_seq #(.N_IN(N), .HOLD_CYC(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .mode(mode_b), .ext_en(ext_en_b), .ext_in(ext_in_b),
        .ext_valid(ext_valid_b), .ext_ready(ext_ready_b), .start(start_b), .stop(stop_b),
        .busy(busy_b), .done(done_b), .out_valid(out_valid_b), .out_in(out_in_b),
        .out_y(out_y_b), .out_pair(out_pair_b));

    typedef struct packed {
        logic [N-1:0]  in;
        logic          y;
        logic [NP-1:0] pair;
    } exp_t;

    typedef struct packed {
        logic [1:0]    mode;
        logic [N-1:0]  in;
        logic          y;
        logic [NP-1:0] pair;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t mon_a_got, mon_a_exp, mon_b_got, mon_b_exp;

    function automatic logic pick(input logic [1:0] m, input logic a, input logic o);
        case (m)
            2'b00:   return ~a;
            2'b01:   return a;
            2'b10:   return ~o;
            default: return o;
        endcase
    endfunction

    // Reference gate model.
    function automatic exp_t model(input logic [N-1:0] v, input logic [1:0] m);
        exp_t e;
        logic a, o;
        e.in = v;
        a = 1'b1;
        o = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            a = a & v[i];
            o = o | v[i];
        end
        e.y = pick(m, a, o);
        for (int k = 0; k < int'(NP); k++) begin
            e.pair[k] = pick(m, v[2*k] & v[2*k+1], v[2*k] | v[2*k+1]);
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Scoreboards: every result is popped and compared.
    always @(negedge clk) begin
        if (out_valid_a === 1'b1) begin
            mon_a_got = {out_in_a, out_y_a, out_pair_a};
            n_cmp++;
            if (q_a.size() == 0) begin
                n_bad++;
                $display("FAIL sb_a unexpected result in=%h y=%b pair=%b", out_in_a, out_y_a, out_pair_a);
            end else begin
                mon_a_exp = q_a.pop_front();
                if (mon_a_got !== mon_a_exp) begin
                    n_bad++;
                    $display("FAIL sb_a got in=%h y=%b pair=%b expected in=%h y=%b pair=%b",
                             mon_a_got.in, mon_a_got.y, mon_a_got.pair,
                             mon_a_exp.in, mon_a_exp.y, mon_a_exp.pair);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid_b === 1'b1) begin
            mon_b_got = {out_in_b, out_y_b, out_pair_b};
            n_cmp++;
            if (q_b.size() == 0) begin
                n_bad++;
                $display("FAIL sb_b unexpected result in=%h y=%b pair=%b", out_in_b, out_y_b, out_pair_b);
            end else begin
                mon_b_exp = q_b.pop_front();
                if (mon_b_got !== mon_b_exp) begin
                    n_bad++;
                    $display("FAIL sb_b got in=%h y=%b pair=%b expected in=%h y=%b pair=%b",
                             mon_b_got.in, mon_b_got.y, mon_b_got.pair,
                             mon_b_exp.in, mon_b_exp.y, mon_b_exp.pair);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        check({name, "_a"}, {out_valid_a, out_in_a, out_y_a, out_pair_a, ext_ready_a, busy_a, done_a}, 32'd0);
        check({name, "_b"}, {out_valid_b, out_in_b, out_y_b, out_pair_b, ext_ready_b, busy_b, done_b}, 32'd0);
    endtask

    task automatic wait_ready_a();
        int w = 0;
        @(negedge clk);
        while (ext_ready_a !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_a_wait", ext_ready_a, 1);
    endtask

    task automatic wait_ready_b();
        int w = 0;
        @(negedge clk);
        while (ext_ready_b !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_b_wait", ext_ready_b, 1);
    endtask

    // Sweep on A (one cycle per pattern) with per-cycle control checks; k counts cycles after start.
    task automatic run_sweep_a(input logic [1:0] m, input int n_out, input int stop_k,
                               input int sw_k, input logic [1:0] m2, input string tag);
        wait_ready_a();
        @(posedge clk); #1;
        start_a     = 1'b1;
        mode_a      = m;
        ext_valid_a = 1'b1;
        ext_in_a    = 4'hF;
        for (int p = 0; p < n_out; p++) begin
            q_a.push_back(model(4'(p % 16), (sw_k >= 0 && p >= sw_k) ? m2 : m));
        end
        for (int k = 1; k <= n_out + 3; k++) begin
            @(posedge clk); #1;
            start_a     = (k == 5 && n_out >= 8);
            ext_valid_a = 1'b0;
            stop_a      = (k == stop_k);
            if (k == sw_k) mode_a = m2;
            @(negedge clk);
            check($sformatf("%s_ctl_k%0d", tag, k), {out_valid_a, busy_a, done_a, ext_ready_a},
                  {28'd0, (k >= 2 && k <= n_out + 1), (k <= n_out + 2), (k == n_out + 2), (k >= n_out + 3)});
        end
        start_a = 1'b0;
        stop_a  = 1'b0;
    endtask

    vec_t tbl[9];

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c_found, last_ov, done_k, done_cnt;

        tbl[0] = '{2'b00, 4'b1111, 1'b0, 2'b00};
        tbl[1] = '{2'b00, 4'b1010, 1'b1, 2'b11};
        tbl[2] = '{2'b01, 4'b1111, 1'b1, 2'b11};
        tbl[3] = '{2'b01, 4'b0011, 1'b0, 2'b01};
        tbl[4] = '{2'b10, 4'b0000, 1'b1, 2'b11};
        tbl[5] = '{2'b10, 4'b0100, 1'b0, 2'b01};
        tbl[6] = '{2'b11, 4'b0000, 1'b0, 2'b00};
        tbl[7] = '{2'b11, 4'b1000, 1'b1, 2'b10};
        tbl[8] = '{2'b00, 4'b0111, 1'b1, 2'b10};

        rst_n = 1'b0;
        mode_a = 2'b00; mode_b = 2'b00;
        ext_en_a = 1'b0; ext_en_b = 1'b0;
        ext_valid_a = 1'b0; ext_valid_b = 1'b0;
        ext_in_a = '0; ext_in_b = '0;
        start_a = 1'b0; start_b = 1'b0;
        stop_a = 1'b0; stop_b = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset_init");
        @(posedge clk); #1;
        rst_n    = 1'b1;
        ext_en_a = 1'b1;
        ext_en_b = 1'b1;

        // External operands: latency and gate values from the table.
        for (int i = 0; i < 9; i++) begin
            wait_ready_a();
            @(posedge clk); #1;
            ext_valid_a = 1'b1;
            ext_in_a    = tbl[i].in;
            mode_a      = tbl[i].mode;
            q_a.push_back('{tbl[i].in, tbl[i].y, tbl[i].pair});
            @(posedge clk); #1;
            ext_valid_a = 1'b0;
            @(negedge clk);
            check($sformatf("ext_early_%0d", i), out_valid_a, 0);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("ext_lat_%0d", i), out_valid_a, 1);
        end

        // ext_en low: port stays closed.
        @(posedge clk); #1;
        ext_en_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ext_valid_a = 1'b1;
        ext_in_a    = 4'h5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("ext_dis_%0d", k), {ext_ready_a, out_valid_a}, 0);
            @(posedge clk); #1;
        end
        ext_valid_a = 1'b0;
        ext_en_a    = 1'b1;

        // Full NAND sweep, then OR sweep stopped during pattern 3.
        run_sweep_a(2'b00, 16, FULL_STOP_A, -1, 2'b00, "sw_nand");
        run_sweep_a(2'b11, 4, 4, -1, 2'b11, "sw_stop");

        // HOLD_CYC=3 NOR sweep on B.
        wait_ready_b();
        @(posedge clk); #1;
        start_b = 1'b1;
        mode_b  = 2'b10;
        for (int p = 0; p < 16; p++) q_b.push_back(model(4'(p), 2'b10));
        last_ov  = 0;
        done_k   = 0;
        done_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            start_b = 1'b0;
            stop_b  = (k == FULL_STOP_B);
            @(negedge clk);
            if (k <= 47)
                check($sformatf("b_ctl_k%0d", k), {out_valid_b, busy_b, done_b},
                      {29'd0, (k >= 2 && (k - 2) % 3 == 0), 1'b1, 1'b0});
            if (out_valid_b === 1'b1) last_ov = k;
            if (done_b === 1'b1) begin
                done_cnt++;
                if (done_k == 0) done_k = k;
                check("b_busy_at_done", busy_b, 1);
            end
            if (done_k != 0 && k == done_k + 1) check("b_busy_after_done", busy_b, 0);
        end
        stop_b = 1'b0;
        check("b_last_ov", last_ov, 47);
        check("b_done_once", done_cnt, 1);
        check("b_done_window", (done_k > 47 && done_k <= 49), 1);

        // Reset mid-sweep once pattern 7 appears.
        wait_ready_a();
        @(posedge clk); #1;
        start_a = 1'b1;
        mode_a  = 2'b01;
        for (int p = 0; p < 16; p++) q_a.push_back(model(4'(p), 2'b01));
        @(posedge clk); #1;
        start_a = 1'b0;
        c_found = 0;
        for (int w = 0; w < 40 && c_found == 0; w++) begin
            @(negedge clk);
            if (out_valid_a === 1'b1 && out_in_a == 4'd7) c_found = 1;
        end
        check("rst_found7", c_found, 1);
        rst_n = 1'b0;
        #1;
        q_a.delete();
        @(posedge clk);
        @(negedge clk);
        check_zero("reset_mid1");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset_mid3");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Restart from pattern 0; mode change applies from pattern 9 onward.
        run_sweep_a(2'b10, 16, FULL_STOP_A, 9, 2'b01, "sw_restart");

`ifdef SWEEP_LOOP_EN
        // Wrap 15 -> 0 without done; stop during pattern 3 of the second pass.
        run_sweep_a(2'b00, 20, 20, -1, 2'b00, "sw_loop");
`endif

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("sb_a_empty", q_a.size(), 0);
        check("sb_b_empty", q_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
